// File: rtl/lcd_display_sysid_checker.sv
// -----------------------------------------------------------------------------
// lcd_display_sysid_checker
//
// Purpose:
//   Reads the system-ID slave (word 0 = ID, word 1 = timestamp) when asked,
//   compares both words against build-time expected values and retries the
//   full read pair on mismatch. Pass/fail and the captured words go to the LCD
//   control logic. This block is the only master on the sysid slave.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset_n          in   synchronous active-low reset
//   start            in   one-cycle request to run a check, ignored while busy
//   sysid_address    out  word select to the sysid slave (0 = ID, 1 = timestamp)
//   sysid_read       out  read strobe, high while a word is being read
//   sysid_readdata   in   32-bit readdata from the sysid slave
//   busy             out  high in RD_ID, RD_TS and COMPARE
//   done             out  high while in DONE
//   pass             out  both words matched (valid when done=1)
//   fail             out  retries exhausted (valid when done=1)
//   id_value         out  last captured word 0
//   timestamp_value  out  last captured word 1
//   retry_count      out  retries used in the current or last check
//   dbg_state        out  current FSM state encoding (debug)
//
// Handshake: start is a single-cycle request. It is registered on the edge
//   that samples it and accepted only in IDLE or DONE; the FSM leaves
//   IDLE/DONE on the following edge. The sysid slave interface holds address
//   and read stable for READ_LATENCY+1 cycles per word and samples readdata
//   only on the final held edge.
//
// Optional feature macro: SYSID_CHECK_PERIODIC_EN
//   When defined, a free-running counter in IDLE/DONE issues an internal
//   start every PERIOD clocks. When undefined, checks run only on start.
// -----------------------------------------------------------------------------
module lcd_display_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1430493118,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned MAX_RETRIES        = 3,
   parameter int unsigned PERIOD             = 50000000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic [3:0]  retry_count,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ID   = 3'd1,
      S_RD_TS   = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   localparam int unsigned CNT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
   localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(READ_LATENCY);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

   generate
      if (MAX_RETRIES > 15 || PERIOD == 0) begin : g_cfg_check
         $error("lcd_display_sysid_checker: MAX_RETRIES must be 0..15 and PERIOD nonzero");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      id_q, id_d;
   logic [31:0]      ts_q, ts_d;
   logic [3:0]       retry_q, retry_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             start_q, start_d;
   logic             idle_like;
   logic             start_any;

   // Only IDLE and DONE accept a new request.
   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

`ifdef SYSID_CHECK_PERIODIC_EN
   localparam logic [31:0] PER_LAST = 32'(PERIOD - 1);

   logic [31:0] per_cnt_q, per_cnt_d;
   logic        int_start;

   // Internal start fires when the idle counter hits its last count; an
   // external start on the same cycle merges into the same request.
   assign int_start = idle_like && !start_q && (per_cnt_q == PER_LAST);
   assign start_any = start || int_start;

   always_comb begin
      per_cnt_d = per_cnt_q;
      if (!idle_like || start || start_q || int_start) begin
         per_cnt_d = 32'd0;
      end else begin
         per_cnt_d = per_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         per_cnt_q <= 32'd0;
      end else begin
         per_cnt_q <= per_cnt_d;
      end
   end
`else
   assign start_any = start;
`endif

   // A second request while one is already registered is dropped so that a
   // pending acceptance never repeats.
   assign start_d = start_any && idle_like && !start_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         id_q    <= 32'd0;
         ts_q    <= 32'd0;
         retry_q <= 4'd0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
         retry_q <= retry_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      ts_d    = ts_q;
      retry_d = retry_q;
      pass_d  = pass_q;
      fail_d  = fail_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_q) begin
               state_d = S_RD_ID;
               cnt_d   = '0;
               retry_d = 4'd0;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
            end
         end
         S_RD_ID: begin
            // readdata is sampled only on the last held cycle.
            if (cnt_q == LAT_LAST) begin
               id_d    = sysid_readdata;
               cnt_d   = '0;
               state_d = S_RD_TS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RD_TS: begin
            if (cnt_q == LAT_LAST) begin
               ts_d    = sysid_readdata;
               cnt_d   = '0;
               state_d = S_COMPARE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_COMPARE: begin
            if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP)) begin
               pass_d  = 1'b1;
               state_d = S_DONE;
            end else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 4'd1;
               state_d = S_RD_ID;
            end else begin
               fail_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Slave strobes and status are pure decodes of the state register, so
   // sysid_address can only move on a state transition.
   assign sysid_read      = (state_q == S_RD_ID) || (state_q == S_RD_TS);
   assign sysid_address   = (state_q == S_RD_TS);
   assign busy            = (state_q == S_RD_ID) || (state_q == S_RD_TS) ||
                            (state_q == S_COMPARE);
   assign done            = (state_q == S_DONE);
   assign pass            = pass_q;
   assign fail            = fail_q;
   assign id_value        = id_q;
   assign timestamp_value = ts_q;
   assign retry_count     = retry_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_lcd_display_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_lcd_display_sysid_checker
//
// Two instances: dut0 with READ_LATENCY=0 and a scriptable slave, dut2 with
// READ_LATENCY=2 and a slave that returns garbage except on the last held
// cycle of each word. Drivers push the expected result record per check;
// monitors pop and compare on each rising edge of done.
// -----------------------------------------------------------------------------
module tb_lcd_display_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1430493118;
   localparam int          W      = 82;

   // Record layout: [81:78] read pairs, [77:70] latency, [69:66] retry,
   // [65] fail, [64] pass, [63:32] id, [31:0] timestamp.

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;
   int   cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic        start0, addr0, read0, busy0, done0, pass0, fail0;
   logic [31:0] rdata0, id0, ts0;
   logic [3:0]  retry0;
   logic [2:0]  dbg0;

   logic        start2, addr2, read2, busy2, done2, pass2, fail2;
   logic [31:0] rdata2, id2, ts2;
   logic [3:0]  retry2;
   logic [2:0]  dbg2;

   lcd_display_sysid_checker #(.READ_LATENCY(0), .MAX_RETRIES(3)) dut0 (
      .clock(clock), .reset_n(reset_n), .start(start0),
      .sysid_address(addr0), .sysid_read(read0), .sysid_readdata(rdata0),
      .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
      .id_value(id0), .timestamp_value(ts0), .retry_count(retry0),
      .dbg_state(dbg0)
   );

   lcd_display_sysid_checker #(.READ_LATENCY(2), .MAX_RETRIES(3)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(start2),
      .sysid_address(addr2), .sysid_read(read2), .sysid_readdata(rdata2),
      .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
      .id_value(id2), .timestamp_value(ts2), .retry_count(retry2),
      .dbg_state(dbg2)
   );

   // ---------------- slave models ----------------
   logic ts_bad    = 1'b0;
   logic transient = 1'b0;
   logic clr_reads = 1'b0;
   int   id_reads0 = 0;

   always @(posedge clock) begin
      if (clr_reads) id_reads0 <= 0;
      else if (read0 && !addr0) id_reads0 <= id_reads0 + 1;
   end

   always_comb begin
      rdata0 = EXP_TS;
      if (!addr0) rdata0 = (transient && id_reads0 == 0) ? 32'd5 : EXP_ID;
      else        rdata0 = ts_bad ? 32'hDEADBEEF : EXP_TS;
   end

   int   hold2      = 0;
   logic last_read2 = 1'b0;
   logic last_addr2 = 1'b0;

   always @(posedge clock) begin
      #1;
      if (read2 && last_read2 && (addr2 == last_addr2)) hold2 = hold2 + 1;
      else hold2 = 0;
      last_read2 = read2;
      last_addr2 = addr2;
   end

   always_comb begin
      rdata2 = 32'hBAD00000 ^ 32'(hold2);
      if (hold2 == 2) rdata2 = addr2 ? EXP_TS : EXP_ID;
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp0_q[$];
   logic [W-1:0] exp2_q[$];
   int           st0_q[$];
   int           st2_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [3:0] pairs, input logic [7:0] lat,
                                       input logic [3:0] rc, input logic f, input logic p,
                                       input logic [31:0] id, input logic [31:0] ts);
      return {pairs, lat, rc, f, p, id, ts};
   endfunction

   task automatic compare_rec(input string tag, input logic [W-1:0] e, input int lat,
                              input bit use_pairs, input int pairs,
                              input logic [3:0] rc, input logic f, input logic p,
                              input logic [31:0] id, input logic [31:0] ts);
      chk({tag, "_latency"}, 32'(lat), 32'(e[77:70]));
      chk({tag, "_retry"},   32'(rc),  32'(e[69:66]));
      chk({tag, "_fail"},    32'(f),   32'(e[65]));
      chk({tag, "_pass"},    32'(p),   32'(e[64]));
      chk({tag, "_id"},      id,       e[63:32]);
      chk({tag, "_ts"},      ts,       e[31:0]);
      if (use_pairs) chk({tag, "_pairs"}, 32'(pairs), 32'(e[81:78]));
   endtask

   // ---------------- monitors ----------------
   logic prev_done0 = 1'b0;
   int   pairs0     = 0;

   always @(posedge clock) begin
      logic [W-1:0] e;
      int s;
      #1;
      if (!reset_n) pairs0 = 0;
      else if (read0 && addr0) pairs0 = pairs0 + 1;
      chk("dut0_pass_and_fail", 32'(pass0 && fail0), 32'd0);
      if (done0 && !prev_done0) begin
         if (exp0_q.size() == 0) begin
            chk("dut0_unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp0_q.pop_front();
            s = st0_q.pop_front();
            compare_rec("dut0", e, cyc - s, 1'b1, pairs0, retry0, fail0, pass0, id0, ts0);
            pairs0 = 0;
         end
      end
      prev_done0 = done0;
   end

   logic prev_done2 = 1'b0;

   always @(posedge clock) begin
      logic [W-1:0] e;
      int s;
      #1;
      if (done2 && !prev_done2) begin
         if (exp2_q.size() == 0) begin
            chk("dut2_unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp2_q.pop_front();
            s = st2_q.pop_front();
            compare_rec("dut2", e, cyc - s, 1'b0, 0, retry2, fail2, pass2, id2, ts2);
         end
      end
      prev_done2 = done2;
   end

   // ---------------- drivers ----------------
   task automatic pulse_raw0();
      @(negedge clock);
      start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
   endtask

   task automatic pulse_start0(input logic [W-1:0] e);
      @(negedge clock);
      exp0_q.push_back(e);
      st0_q.push_back(cyc + 1);
      start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
   endtask

   task automatic pulse_start2(input logic [W-1:0] e);
      @(negedge clock);
      exp2_q.push_back(e);
      st2_q.push_back(cyc + 1);
      start2 = 1'b1;
      @(negedge clock);
      start2 = 1'b0;
   endtask

   task automatic wait_empty0(input int budget);
      int n = 0;
      while (exp0_q.size() != 0 && n < budget) begin
         @(posedge clock);
         n++;
      end
      #2;
      if (exp0_q.size() != 0) begin
         chk("dut0_done_timeout", 32'(exp0_q.size()), 32'd0);
         exp0_q.delete();
         st0_q.delete();
      end
   endtask

   task automatic wait_empty2(input int budget);
      int n = 0;
      while (exp2_q.size() != 0 && n < budget) begin
         @(posedge clock);
         n++;
      end
      #2;
      if (exp2_q.size() != 0) begin
         chk("dut2_done_timeout", 32'(exp2_q.size()), 32'd0);
         exp2_q.delete();
         st2_q.delete();
      end
   endtask

   task automatic check_zero0(input string tag);
      chk({tag, "_busy"},  32'(busy0),  32'd0);
      chk({tag, "_done"},  32'(done0),  32'd0);
      chk({tag, "_pass"},  32'(pass0),  32'd0);
      chk({tag, "_fail"},  32'(fail0),  32'd0);
      chk({tag, "_read"},  32'(read0),  32'd0);
      chk({tag, "_addr"},  32'(addr0),  32'd0);
      chk({tag, "_id"},    id0,         32'd0);
      chk({tag, "_ts"},    ts0,         32'd0);
      chk({tag, "_retry"}, 32'(retry0), 32'd0);
      chk({tag, "_state"}, 32'(dbg0),   32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit found;
      reset_n = 1'b0;
      start0  = 1'b0;
      start2  = 1'b0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check_zero0("reset0");
      chk("reset2_done", 32'(done2), 32'd0);
      chk("reset2_busy", 32'(busy2), 32'd0);
      chk("reset2_read", 32'(read2), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_zero0("idle0");

      // Match, latency 0 and latency 2 (garbage on non-final held cycles)
      pulse_start0(mk(4'd1, 8'd4, 4'd0, 1'b0, 1'b1, EXP_ID, EXP_TS));
      wait_empty0(50);
      pulse_start2(mk(4'd0, 8'd8, 4'd0, 1'b0, 1'b1, EXP_ID, EXP_TS));
      wait_empty2(50);

      // Persistent timestamp mismatch, launched from DONE
      ts_bad = 1'b1;
      pulse_start0(mk(4'd4, 8'd13, 4'd3, 1'b1, 1'b0, EXP_ID, 32'hDEADBEEF));
      @(posedge clock);
      #1;
      chk("rerun_done_cleared", 32'(done0), 32'd0);
      chk("rerun_pass_cleared", 32'(pass0), 32'd0);
      chk("rerun_busy",         32'(busy0), 32'd1);
      wait_empty0(100);

      // Transient ID mismatch on the first read only
      ts_bad = 1'b0;
      @(negedge clock);
      clr_reads = 1'b1;
      @(negedge clock);
      clr_reads = 1'b0;
      transient = 1'b1;
      pulse_start0(mk(4'd2, 8'd7, 4'd1, 1'b0, 1'b1, EXP_ID, EXP_TS));
      wait_empty0(60);
      transient = 1'b0;

      // Start while busy must not restart the check
      pulse_start0(mk(4'd1, 8'd4, 4'd0, 1'b0, 1'b1, EXP_ID, EXP_TS));
      @(negedge clock);
      start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      wait_empty0(50);
      repeat (10) @(posedge clock);

      // Reset during the second RD_TS of a failing check
      ts_bad = 1'b1;
      pulse_raw0();
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(posedge clock);
         #1;
         if (read0 && addr0 && retry0 == 4'd1) found = 1'b1;
      end
      chk("reach_rd_ts_retry1", 32'(found), 32'd1);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check_zero0("midreset0");
      chk("midreset2_done", 32'(done2), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      ts_bad  = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      chk("after_reset_done", 32'(done0), 32'd0);
      chk("after_reset_busy", 32'(busy0), 32'd0);

      // Recovery after reset
      pulse_start0(mk(4'd1, 8'd4, 4'd0, 1'b0, 1'b1, EXP_ID, EXP_TS));
      wait_empty0(50);
      repeat (5) @(posedge clock);
      #1;
      chk("final_queue0_empty", 32'(exp0_q.size()), 32'd0);
      chk("final_queue2_empty", 32'(exp2_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
